addsub_pipe: RTL and testbench

//   Parametrised pipelined two's-complement add/subtract unit for the ALU datapath.

---
 rtl/addsub_pipe.sv | 142 ++++++++++++++
 tb/tb_addsub_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pipe
//  Description : Pipelined two's-complement add/subtract unit. The carry
//                chain is cut into STAGES equal slices and one slice is
//                resolved per pipeline stage. Valid/ready handshake on both
//                sides with a global stall. Status flags come from the
//                final stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
    parameter int WIDTH  = 32,   // operand width, multiple of STAGES
    parameter int STAGES = 4     // pipeline depth / number of carry slices (1..8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;
    // Operands only need to travel up to the stage that adds the top slice,
    // so the last stage keeps just the finished result and flags.
    localparam int NOPS  = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage pipeline registers
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            cy_q,    cy_d;     // carry out of the newest slice
    logic [STAGES-1:0][WIDTH-1:0] sum_q,   sum_d;    // slices resolved so far
    logic [NOPS-1:0][WIDTH-1:0]   opa_q,   opa_d;    // operand A riding along
    logic [NOPS-1:0][WIDTH-1:0]   opb_q,   opb_d;    // operand B, already inverted for sub
    logic                         ovf_q,   ovf_d;
    logic                         zero_q,  zero_d;

    // Inputs seen by each stage: ports for stage 0, previous register otherwise
    logic [STAGES-1:0]            si_v;
    logic [STAGES-1:0]            si_c;
    logic [STAGES-1:0][WIDTH-1:0] si_a;
    logic [STAGES-1:0][WIDTH-1:0] si_b;
    logic [STAGES-1:0][WIDTH-1:0] si_sum;

    logic stall;

    // A result waiting on a busy consumer freezes the whole pipe
    assign stall    = valid_q[LAST] & ~out_ready;
    assign in_ready = ~stall;

    // Route each stage's operands: stage 0 from the ports, stage k from stage k-1
    always_comb begin
        si_v   = '0;
        si_c   = '0;
        si_a   = '0;
        si_b   = '0;
        si_sum = '0;
        si_v[0]   = in_valid;
        si_c[0]   = sub;                 // the +1 of a + ~b + 1
        si_a[0]   = a;
        si_b[0]   = sub ? ~b : b;
        si_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            si_v[k]   = valid_q[k-1];
            si_c[k]   = cy_q[k-1];
            si_a[k]   = opa_q[k-1];
            si_b[k]   = opb_q[k-1];
            si_sum[k] = sum_q[k-1];
        end
    end

    // Each stage adds its own slice and forwards everything else untouched
    always_comb begin
        logic [SLICE:0]   slice_sum;
        logic [WIDTH-1:0] full;
        slice_sum = '0;
        full      = '0;
        valid_d   = '0;
        cy_d      = '0;
        sum_d     = '0;
        opa_d     = '0;
        opb_d     = '0;
        ovf_d     = 1'b0;
        zero_d    = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            slice_sum = {1'b0, si_a[k][k*SLICE +: SLICE]}
                      + {1'b0, si_b[k][k*SLICE +: SLICE]}
                      + (SLICE+1)'(si_c[k]);
            sum_d[k]                   = si_sum[k];
            sum_d[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            cy_d[k]                    = slice_sum[SLICE];
            valid_d[k]                 = si_v[k];
        end
        for (int k = 0; k < LAST; k++) begin
            opa_d[k] = si_a[k];
            opb_d[k] = si_b[k];
        end
        // B is pre-inverted for subtract, so one same-sign test covers both ops
        full   = sum_d[LAST];
        ovf_d  = (si_a[LAST][WIDTH-1] == si_b[LAST][WIDTH-1]) &&
                 (full[WIDTH-1] != si_a[LAST][WIDTH-1]);
        zero_d = ~|full;
    end

    // Pipeline registers: cleared on reset, all held together during a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            cy_q    <= '0;
            sum_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign result    = sum_q[LAST];
    assign carry     = cy_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = sum_q[LAST][WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_pipe
//  Description : Self-checking bench for addsub_pipe, an 8-bit/2-stage and a
//                32-bit/4-stage instance checked against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       v8, r8, s8, ov8, or8, c8, o8, z8, n8;
    logic [7:0] a8, b8, res8;

    logic        v32, r32, s32, ov32, or32, c32, o32, z32, n32;
    logic [31:0] a32, b32, res32;

    addsub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .sub(s8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .carry(c8), .overflow(o8), .zero(z8), .negative(n8)
    );

    addsub_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .sub(s32), .out_valid(ov32), .out_ready(or32),
        .result(res32), .carry(c32), .overflow(o32), .zero(z32), .negative(n32)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // flg = {carry, overflow, zero, negative}
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    // Reference: ideal signed result, reduced mod 2^w; unsigned compare for carry
    function automatic exp_t model(input int w, input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        exp_t   e;
        longint mask, half, ua, ub, sa, sb, ideal, r;
        logic   cy, ov;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(xa) & mask;
        ub    = longint'(xb) & mask;
        sa    = (ua >= half) ? ua - (mask + 1) : ua;
        sb    = (ub >= half) ? ub - (mask + 1) : ub;
        ideal = xs ? sa - sb : sa + sb;
        r     = ideal & mask;
        cy    = xs ? (ua >= ub) : ((ua + ub) > mask);
        ov    = (ideal >= half) || (ideal < -half);
        e.res = r[31:0];
        e.flg = {cy, ov, (r == 0), r[w-1]};
        return e;
    endfunction

    exp_t        q8[$];
    exp_t        q32[$];
    exp_t        e8, e32;
    int          pops32 = 0;
    logic        stall_prev32 = 1'b0;
    logic [35:0] held32 = '0;

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (reset) begin
            q8.delete();
            q32.delete();
            stall_prev32 = 1'b0;
        end else begin
            if (v8 && r8)
                q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, s8));
            if (ov8 && or8) begin
                check_val("u8 beat expected", q8.size() > 0, 1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    check_val("u8 result", res8, e8.res[7:0]);
                    check_val("u8 flags", {c8, o8, z8, n8}, e8.flg);
                end
            end
            if (v32 && r32)
                q32.push_back(model(32, a32, b32, s32));
            if (ov32 && or32) begin
                pops32++;
                check_val("u32 beat expected", q32.size() > 0, 1);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    check_val("u32 result", res32, e32.res);
                    check_val("u32 flags", {c32, o32, z32, n32}, e32.flg);
                end
            end
            if (ov32 && !or32) begin
                check_val("u32 in_ready during stall", r32, 0);
                if (stall_prev32)
                    check_val("u32 output held", {res32, c32, o32, z32, n32}, held32);
                held32       = {res32, c32, o32, z32, n32};
                stall_prev32 = 1'b1;
            end else begin
                stall_prev32 = 1'b0;
            end
        end
    end

    task automatic single8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                           input logic [7:0] er, input logic [3:0] ef, input string tag);
        int n;
        a8 = xa; b8 = xb; s8 = xs; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        n  = 1;
        while (!ov8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, " latency"}, n, 2);
        check_val({tag, " result"}, res8, er);
        check_val({tag, " flags"}, {c8, o8, z8, n8}, ef);
        @(posedge clk); #1;
    endtask

    task automatic single32(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                            input logic [31:0] er, input logic [3:0] ef, input string tag);
        int n;
        a32 = xa; b32 = xb; s32 = xs; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        n   = 1;
        while (!ov32 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, " latency"}, n, 4);
        check_val({tag, " result"}, res32, er);
        check_val({tag, " flags"}, {c32, o32, z32, n32}, ef);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   first, p0, n_acc, cyc;
        logic acc;
        reset = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset u32 out_valid", ov32, 0);
        check_val("reset u32 outputs", {res32, c32, o32, z32, n32}, 0);
        check_val("reset u8 outputs", {ov8, res8, c8, o8, z8, n8}, 0);
        check_val("reset u32 in_ready", r32, 1);
        reset = 1'b0;

        // Directed arithmetic corners
        single8(8'h05, 8'h03, 1'b1, 8'h02, 4'b1000, "t1 5-3");
        single8(8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, "t2 7F+1");
        single8(8'h80, 8'h01, 1'b1, 8'h7F, 4'b1100, "t2 80-1");
        single32(32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0, 4'b1010, "t3 equal sub");
        single32(32'h0, 32'h1, 1'b1, 32'hFFFFFFFF, 4'b0001, "t3 0-1");
        single32(32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 4'b1010, "wrap add");
        single32(32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 4'b1100, "min-1 sub");

        // Back-to-back random stream on the 2-stage unit
        for (int i = 0; i < 10; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
            @(posedge clk); #1;
        end
        v8 = 1'b0;

        // 16 back-to-back beats, full rate, first result after 4 cycles
        p0    = pops32;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1)); v32 = 1'b1;
            @(posedge clk); #1;
            if (ov32 && first < 0) first = i + 1;
        end
        v32 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("t4 first latency", first, 4);
        check_val("t4 beats at full rate", pops32 - p0, 16);

        // Backpressure: 5 stalled cycles mid-stream, then random ready/valid
        p0    = pops32;
        n_acc = 0;
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
        for (cyc = 0; cyc < 100; cyc++) begin
            if (cyc < 40) begin
                or32 = !(cyc >= 8 && cyc < 13);
                v32  = (cyc < 30);
            end else if (cyc < 90) begin
                or32 = 1'($urandom_range(0, 1));
                if (!v32) v32 = 1'($urandom_range(0, 1));
            end else begin
                or32 = 1'b1;
                v32  = 1'b0;
            end
            @(negedge clk);
            acc = v32 && r32;
            if (acc) n_acc++;
            @(posedge clk); #1;
            if (acc) begin
                a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
                if (cyc >= 40) v32 = 1'($urandom_range(0, 1));
            end
        end
        or32 = 1'b1;
        v32  = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("t5 no loss or duplication", pops32 - p0, n_acc);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1)); v32 = 1'b1;
            @(posedge clk); #1;
        end
        v32   = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("t6 flushed out_valid", ov32, 0);
        check_val("t6 flushed outputs", {res32, c32, o32, z32, n32}, 0);
        reset = 1'b0;
        single32(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 4'b0000, "t6 after reset");

        repeat (10) @(posedge clk);
        #1;
        check_val("u8 scoreboard drained", q8.size(), 0);
        check_val("u32 scoreboard drained", q32.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
